// File: rtl/dispatch_iq_steer.sv
// Dispatch-group buffer that steers uops in program order into per-FU issue-queue write ports,
// with per-FU credit backpressure and synchronous flush.
module dispatch_iq_steer #(
    parameter int unsigned DISP_WIDTH = 2,
    parameter int unsigned NUM_FUS    = 4,
    parameter int unsigned IQ_DEPTH   = 8,
    parameter int unsigned UOP_W      = 64,
    parameter int unsigned FU_IDX_W   = $clog2(NUM_FUS),
    parameter int unsigned CRD_W      = $clog2(IQ_DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DISP_WIDTH-1:0]          disp_valid,
    input  logic [DISP_WIDTH*UOP_W-1:0]    disp_uop,
    input  logic [DISP_WIDTH*FU_IDX_W-1:0] disp_fu,
    output logic                           disp_ready,
    output logic [NUM_FUS-1:0]             iq_valid,
    output logic [NUM_FUS*UOP_W-1:0]       iq_uop,
    input  logic [NUM_FUS-1:0]             iq_credit_ret,
    input  logic                           flush,
    output logic                           buf_empty,
    output logic                           credit_err
);

    localparam logic [CRD_W-1:0] CrdMax = CRD_W'(IQ_DEPTH);

    logic [DISP_WIDTH-1:0]                pend_q, pend_d;
    logic [DISP_WIDTH-1:0][UOP_W-1:0]     uop_q, uop_d;
    logic [DISP_WIDTH-1:0][FU_IDX_W-1:0]  fu_q, fu_d;
    logic [NUM_FUS-1:0][CRD_W-1:0]        credit_q, credit_d;
    logic                                 credit_err_q, credit_err_d;

    logic [DISP_WIDTH-1:0] send;
    logic [NUM_FUS-1:0]    fu_busy;
    logic                  blocked;
    logic                  accept;

    // In-order steering: the first pending entry that cannot send stops all younger ones.
    always_comb begin
        send     = '0;
        fu_busy  = '0;
        blocked  = 1'b0;
        iq_valid = '0;
        iq_uop   = '0;
        for (int k = 0; k < DISP_WIDTH; k++) begin
            if (pend_q[k] && !blocked) begin
                if (credit_q[fu_q[k]] != '0 && !fu_busy[fu_q[k]]) begin
                    send[k]          = 1'b1;
                    fu_busy[fu_q[k]] = 1'b1;
                end else begin
                    blocked = 1'b1;
                end
            end
        end
        if (!flush) begin
            iq_valid = fu_busy;
            for (int k = 0; k < DISP_WIDTH; k++) begin
                if (send[k]) begin
                    iq_uop[int'(fu_q[k])*UOP_W +: UOP_W] = uop_q[k];
                end
            end
        end
    end

    assign disp_ready = !flush && ((pend_q & ~send) == '0);
    assign buf_empty  = (pend_q == '0);
    assign credit_err = credit_err_q;
    assign accept     = disp_ready && (disp_valid != '0);

    always_comb begin
        pend_d = pend_q & ~send;
        uop_d  = uop_q;
        fu_d   = fu_q;
        if (flush) begin
            pend_d = '0;
        end else if (accept) begin
            pend_d = disp_valid;
            for (int k = 0; k < DISP_WIDTH; k++) begin
                uop_d[k] = disp_uop[k*UOP_W +: UOP_W];
                fu_d[k]  = disp_fu[k*FU_IDX_W +: FU_IDX_W];
            end
        end
    end

    // A return at full credit with no send is an accounting error; the count saturates.
    always_comb begin
        credit_d     = credit_q;
        credit_err_d = credit_err_q;
        for (int f = 0; f < NUM_FUS; f++) begin
            if (flush) begin
                credit_d[f] = CrdMax;
            end else begin
                case ({iq_valid[f], iq_credit_ret[f]})
                    2'b10:   credit_d[f] = credit_q[f] - 1'b1;
                    2'b01: begin
                        if (credit_q[f] == CrdMax) begin
                            credit_err_d = 1'b1;
                        end else begin
                            credit_d[f] = credit_q[f] + 1'b1;
                        end
                    end
                    default: credit_d[f] = credit_q[f];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q       <= '0;
            uop_q        <= '0;
            fu_q         <= '0;
            credit_q     <= {NUM_FUS{CrdMax}};
            credit_err_q <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            uop_q        <= uop_d;
            fu_q         <= fu_d;
            credit_q     <= credit_d;
            credit_err_q <= credit_err_d;
        end
    end

endmodule

// File: tb/tb_dispatch_iq_steer.sv
// Directed bench for dispatch_iq_steer: expected IQ writes are queued by the stimulus and
// popped by a negedge monitor; control outputs and credits are checked inline.
module tb_dispatch_iq_steer;

    localparam int DW = 2;
    localparam int NF = 4;
    localparam int UW = 64;
    localparam int FW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [DW-1:0]     disp_valid;
    logic [DW*UW-1:0]  disp_uop;
    logic [DW*FW-1:0]  disp_fu;
    logic              disp_ready;
    logic [NF-1:0]     iq_valid;
    logic [NF*UW-1:0]  iq_uop;
    logic [NF-1:0]     iq_credit_ret;
    logic              flush;
    logic              buf_empty;
    logic              credit_err;

    typedef struct packed {
        logic [FW-1:0] fu;
        logic [UW-1:0] uop;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    dispatch_iq_steer #(
        .DISP_WIDTH(DW),
        .NUM_FUS   (NF),
        .IQ_DEPTH  (8),
        .UOP_W     (UW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .disp_valid   (disp_valid),
        .disp_uop     (disp_uop),
        .disp_fu      (disp_fu),
        .disp_ready   (disp_ready),
        .iq_valid     (iq_valid),
        .iq_uop       (iq_uop),
        .iq_credit_ret(iq_credit_ret),
        .flush        (flush),
        .buf_empty    (buf_empty),
        .credit_err   (credit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_grp(input logic [DW-1:0] v, input logic [UW-1:0] u0, input logic [FW-1:0] f0,
                           input logic [UW-1:0] u1, input logic [FW-1:0] f1);
        disp_valid = v;
        disp_uop   = {u1, u0};
        disp_fu    = {f1, f0};
    endtask

    task automatic clr_grp();
        disp_valid = '0;
        disp_uop   = '0;
        disp_fu    = '0;
    endtask

    task automatic exp_wr(input logic [FW-1:0] f, input logic [UW-1:0] u);
        wr_t e;
        e.fu  = f;
        e.uop = u;
        exp_q.push_back(e);
    endtask

    task automatic chk_credits(input string name, input int c0, input int c1, input int c2,
                               input int c3);
        int exp_c[NF];
        exp_c = '{c0, c1, c2, c3};
        for (int f = 0; f < NF; f++) begin
            chk($sformatf("%s_credit%0d", name, f), 64'(dut.credit_q[f]), 64'(exp_c[f]));
        end
    endtask

    // Monitor: every IQ write must match the head of the scoreboard; idle ports carry zero.
    always @(negedge clk) begin
        logic [UW-1:0] u;
        wr_t           e;
        if (!rst) begin
            for (int f = 0; f < NF; f++) begin
                u = iq_uop[f*UW +: UW];
                if (iq_valid[f]) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: fu=%0d uop=0x%0h, expected no write", f, u);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wr_fu", 64'(f), 64'(e.fu));
                        chk("wr_uop", u, e.uop);
                    end
                end else begin
                    chk($sformatf("idle_uop_zero_fu%0d", f), u, 64'h0);
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!rst && disp_valid != '0) begin
            assert (((disp_valid + 1'b1) & disp_valid) == '0)
                else $error("non-contiguous disp_valid %b", disp_valid);
            for (int k = 0; k < DW; k++) begin
                if (disp_valid[k]) begin
                    assert (int'(disp_fu[k*FW +: FW]) < NF)
                        else $error("disp_fu out of range in slot %0d", k);
                end
            end
        end
    end

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        iq_credit_ret = '0;
        clr_grp();
        #2;
        chk("rst_iq_valid", 64'(iq_valid), 64'h0);
        chk("rst_iq_uop_any", 64'(|iq_uop), 64'h0);
        chk("rst_buf_empty", 64'(buf_empty), 64'h1);
        chk("rst_disp_ready", 64'(disp_ready), 64'h1);
        chk("rst_credit_err", 64'(credit_err), 64'h0);
        chk_credits("rst", 8, 8, 8, 8);
        #10 rst = 1'b0;
        tick();

        // Two uops to distinct FUs go out together.
        set_grp(2'b11, 64'hA, 2'd1, 64'hB, 2'd2);
        exp_wr(2'd1, 64'hA);
        exp_wr(2'd2, 64'hB);
        #1 chk("t1_ready_pre", 64'(disp_ready), 64'h1);
        tick();
        clr_grp();
        #1;
        chk("t1_iq_valid", 64'(iq_valid), 64'h6);
        chk("t1_ready", 64'(disp_ready), 64'h1);
        chk("t1_buf_empty", 64'(buf_empty), 64'h0);
        tick();
        chk("t1_idle", 64'(iq_valid), 64'h0);
        chk("t1_empty_after", 64'(buf_empty), 64'h1);
        chk_credits("t1", 8, 7, 7, 8);

        // Same-FU pair serialises over two cycles.
        set_grp(2'b11, 64'hC, 2'd3, 64'hD, 2'd3);
        exp_wr(2'd3, 64'hC);
        exp_wr(2'd3, 64'hD);
        tick();
        clr_grp();
        #1;
        chk("t2_c1_iq_valid", 64'(iq_valid), 64'h8);
        chk("t2_c1_ready", 64'(disp_ready), 64'h0);
        tick();
        chk("t2_c2_iq_valid", 64'(iq_valid), 64'h8);
        chk("t2_c2_ready", 64'(disp_ready), 64'h1);
        tick();
        chk("t2_empty", 64'(buf_empty), 64'h1);
        chk_credits("t2", 8, 7, 7, 6);

        // Exhaust fu0 credits; the ninth uop waits for a return.
        for (int i = 0; i < 9; i++) begin
            set_grp(2'b01, 64'h100 + 64'(i), 2'd0, 64'h0, 2'd0);
            if (i < 8) exp_wr(2'd0, 64'h100 + 64'(i));
            #1 chk($sformatf("t3_ready_%0d", i), 64'(disp_ready), 64'h1);
            tick();
        end
        clr_grp();
        #1;
        chk("t3_held_iq_valid", 64'(iq_valid), 64'h0);
        chk("t3_held_ready", 64'(disp_ready), 64'h0);
        chk("t3_held_empty", 64'(buf_empty), 64'h0);
        chk_credits("t3_zero", 0, 7, 7, 6);
        exp_wr(2'd0, 64'h108);
        tick();
        chk("t3_still_held", 64'(iq_valid), 64'h0);
        iq_credit_ret = 4'b0001;
        tick();
        iq_credit_ret = '0;
        #1;
        chk("t3_ninth_sent", 64'(iq_valid), 64'h1);
        chk("t3_ninth_ready", 64'(disp_ready), 64'h1);
        tick();
        chk("t3_empty", 64'(buf_empty), 64'h1);
        chk_credits("t3_end", 0, 7, 7, 6);

        // Oldest uop blocked on credit holds back a sendable younger one.
        iq_credit_ret = 4'b1110;
        tick();
        iq_credit_ret = 4'b1000;
        tick();
        iq_credit_ret = '0;
        chk_credits("t4_pre", 0, 8, 8, 8);
        set_grp(2'b11, 64'hE, 2'd0, 64'hF, 2'd1);
        exp_wr(2'd0, 64'hE);
        exp_wr(2'd1, 64'hF);
        tick();
        clr_grp();
        #1;
        chk("t4_blocked_iq_valid", 64'(iq_valid), 64'h0);
        chk("t4_blocked_ready", 64'(disp_ready), 64'h0);
        tick();
        chk("t4_blocked2_iq_valid", 64'(iq_valid), 64'h0);
        iq_credit_ret = 4'b0001;
        tick();
        iq_credit_ret = '0;
        #1;
        chk("t4_both_sent", 64'(iq_valid), 64'h3);
        chk("t4_ready", 64'(disp_ready), 64'h1);
        tick();
        chk("t4_empty", 64'(buf_empty), 64'h1);
        chk_credits("t4_end", 0, 7, 8, 8);

        // Flush a blocked uop; input and credit returns in the flush cycle are dropped.
        set_grp(2'b01, 64'h66, 2'd0, 64'h0, 2'd0);
        tick();
        clr_grp();
        #1;
        chk("t5_blocked_iq_valid", 64'(iq_valid), 64'h0);
        chk("t5_blocked_empty", 64'(buf_empty), 64'h0);
        flush         = 1'b1;
        iq_credit_ret = 4'b0100;
        set_grp(2'b01, 64'h77, 2'd2, 64'h0, 2'd0);
        #1;
        chk("t5_flush_ready", 64'(disp_ready), 64'h0);
        chk("t5_flush_iq_valid", 64'(iq_valid), 64'h0);
        tick();
        flush         = 1'b0;
        iq_credit_ret = '0;
        clr_grp();
        #1;
        chk("t5_empty", 64'(buf_empty), 64'h1);
        chk("t5_ready", 64'(disp_ready), 64'h1);
        chk("t5_credit_err", 64'(credit_err), 64'h0);
        chk_credits("t5", 8, 8, 8, 8);

        // Flush squashes a uop that would otherwise send this cycle.
        set_grp(2'b01, 64'h88, 2'd3, 64'h0, 2'd0);
        tick();
        clr_grp();
        flush = 1'b1;
        #1 chk("t5b_flush_gates_send", 64'(iq_valid), 64'h0);
        tick();
        flush = 1'b0;
        #1;
        chk("t5b_empty", 64'(buf_empty), 64'h1);
        chk_credits("t5b", 8, 8, 8, 8);

        // Return at full credit sets a sticky error; send+return on one FU nets to zero.
        iq_credit_ret = 4'b0100;
        tick();
        iq_credit_ret = '0;
        #1;
        chk("t6_err_set", 64'(credit_err), 64'h1);
        chk_credits("t6_sat", 8, 8, 8, 8);
        set_grp(2'b01, 64'h99, 2'd1, 64'h0, 2'd0);
        exp_wr(2'd1, 64'h99);
        tick();
        clr_grp();
        iq_credit_ret = 4'b0010;
        #1 chk("t6_send_fu1", 64'(iq_valid), 64'h2);
        tick();
        iq_credit_ret = '0;
        #1;
        chk_credits("t6_net", 8, 8, 8, 8);
        tick();
        chk("t6_err_sticky", 64'(credit_err), 64'h1);

        // Asynchronous reset mid-group drops the younger pending uop.
        set_grp(2'b11, 64'hAA, 2'd2, 64'hBB, 2'd2);
        exp_wr(2'd2, 64'hAA);
        tick();
        clr_grp();
        #1 chk("t7_first_sent", 64'(iq_valid), 64'h4);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t7_rst_empty", 64'(buf_empty), 64'h1);
        chk("t7_rst_iq_valid", 64'(iq_valid), 64'h0);
        chk("t7_rst_err_clear", 64'(credit_err), 64'h0);
        chk("t7_rst_ready", 64'(disp_ready), 64'h1);
        tick();
        rst = 1'b0;
        tick();
        chk("t7_no_write", 64'(iq_valid), 64'h0);
        chk_credits("t7", 8, 8, 8, 8);
        tick();

        chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
